// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit qualify, mid-bit sampling, stop check, FIFO write strobe.
// Optional two-flop input synchroniser enabled by defining UART_RX_SYNC_EN.
//
// state | meaning
// IDLE  | line idle, waiting for rxd_s = 0
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits LSB first, one per CLKS_PER_BIT cycles
// STOP  | sampling stop bit, then write / frame_err / overrun_err
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       full,
  output logic [7:0] data_out,
  output logic       fifo_wr_en,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [TW-1:0] TICK_HALF = TW'(H);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          wr_q, wr_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;
  logic          busy_q, busy_d;
  logic          rxd_s;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;
`else
  assign rxd_s = rxd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          // With H = 0 the start bit centre is this very cycle.
          if (H == 0) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = START;
            tick_d  = TICK_ONE;
          end
        end
      end

      START: begin
        tick_d = tick_q + TICK_ONE;
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          if (!rxd_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        tick_d = tick_q + TICK_ONE;
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        tick_d = tick_q + TICK_ONE;
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          if (!rxd_s) begin
            ferr_d = 1'b1;
          end else if (full) begin
            oerr_d = 1'b1;
          end else begin
            wr_d   = 1'b1;
            data_d = shift_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign data_out    = data_q;
  assign fifo_wr_en  = wr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign busy        = busy_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver; the receive-side counterpart of the controller's transmitter. It samples an 8N1 stream on `rxd`: one start bit (0), eight data bits LSB first, one stop bit (1). It validates each frame and pushes every good byte into the RX FIFO through a single-cycle write strobe. It also flags framing errors and bytes dropped because the FIFO was full.

## Interface
- `CLKS_PER_BIT`, default 1 — clock cycles per serial bit, legal range 1..1024; 1 matches the transmitter's one-bit-per-clock rate.
- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `rxd`  in  1  — serial input; idles high.
- `full`  in  1  — RX FIFO full flag.
- `data_out`  out  8  — received byte; valid only while `fifo_wr_en`=1.
- `fifo_wr_en`  out  1  — one-cycle write strobe to the RX FIFO.
- `frame_err`  out  1  — one-cycle pulse when the stop bit samples 0.
- `overrun_err`  out  1  — one-cycle pulse when a good byte is dropped because `full`=1.
- `busy`  out  1  — high in every state except IDLE.

## Operation
- `rxd_s` is the sampled serial line; see Configuration for how it is derived.
- Define H = (CLKS_PER_BIT-1)/2, using integer division.
- `tick_cnt` is ceil(log2(CLKS_PER_BIT)) bits wide, minimum 1. `bit_idx` is 3 bits. The shift register is 8 bits.
- States are IDLE, START, DATA and STOP.
- IDLE:
  - When `rxd_s`=0, the current cycle is tick 0 of the start bit.
  - If H=0, go to DATA with `tick_cnt`=0 and `bit_idx`=0.
  - Otherwise go to START with `tick_cnt`=1.
- START:
  - Increment `tick_cnt` each cycle.
  - At `tick_cnt`=H, if `rxd_s`=0, go to DATA with `tick_cnt`=0 and `bit_idx`=0.
  - At `tick_cnt`=H, if `rxd_s`=1, treat it as a glitch and return to IDLE. No output is produced.
- DATA:
  - Increment `tick_cnt` each cycle.
  - At `tick_cnt`=CLKS_PER_BIT-1, shift `rxd_s` into bit 7 of the shift register (right shift, so data ends up LSB first) and clear `tick_cnt`.
  - After the 8th sample (`bit_idx`=7), go to STOP; otherwise increment `bit_idx`.
- STOP:
  - At `tick_cnt`=CLKS_PER_BIT-1, sample `rxd_s` and return to IDLE.
  - Sample 1 and `full`=0: on the next cycle, `fifo_wr_en`=1 and `data_out`=shift register.
  - Sample 1 and `full`=1: the byte is dropped; `overrun_err` pulses; `fifo_wr_en` stays 0.
  - Sample 0: `frame_err` pulses and the byte is dropped. No resynchronisation is attempted: IDLE waits for `rxd_s`=0 again.
- `full` is evaluated in the same cycle as the stop-bit sample.
- Reset values:
  - State = IDLE.
  - `tick_cnt`, `bit_idx`, shift register = 0.
  - `data_out`=0, `fifo_wr_en`=0, `frame_err`=0, `overrun_err`=0, `busy`=0.
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame with no write and no error pulse. The remaining bits of that frame are parsed as new frames; this is accepted behaviour.
- At most one of `fifo_wr_en`, `frame_err`, `overrun_err` is high in any cycle.

## Timing
- All outputs are registered.
- Below, cycle 0 is the first cycle in which `rxd_s`=0 for the start bit, and N = CLKS_PER_BIT.
- N=1:
  - Data bits are sampled in cycles 1..8 and the stop bit in cycle 9.
  - `fifo_wr_en` is high in cycle 10.
  - IDLE is entered in cycle 10, so a new start bit is accepted from cycle 10 onward, i.e. back-to-back frames with zero idle gap.
- General N:
  - Data bit k is sampled at cycle H+1+(k+1)·N-1 relative to cycle 0, which is the centre of bit k for N≥3.
  - The stop bit is sampled at H+9N.
  - The write strobe follows one cycle later, at H+9N+1.
- Latency from `rxd` edge to `rxd_s` is 0 cycles without the synchroniser and 2 cycles with it.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rxd` passes through a two-flop synchroniser, both flops reset to 1.
  - Every timing figure above shifts by +2 cycles relative to `rxd`.
  - Required when `rxd` is driven from an external pin.
- Not defined:
  - `rxd_s` = `rxd` directly, with no added latency.
  - Used for same-clock loopback from the transmitter.

## Test plan
- **Single byte (N=1, no sync).**
  - Stimulus: drive `rxd` = 0, then 1,0,1,0,0,1,0,1 (0xA5, LSB first), then 1, then idle high.
  - Required: `fifo_wr_en` is high for exactly 1 cycle, 10 cycles after the start bit, with `data_out`=0xA5; no error pulses.
- **Back-to-back bytes (N=1).**
  - Stimulus: 0x00 and 0xFF with zero idle cycles between frames.
  - Required: two strobes 10 cycles apart, with data 0x00 then 0xFF.
- **Framing error (N=4).**
  - Stimulus: byte 0x3C sent with a stop bit of 0.
  - Required: `frame_err` pulses once at cycle H+9N+1 = 38; no `fifo_wr_en`.
- **Overrun (N=1).**
  - Stimulus: hold `full`=1 and send 0x81.
  - Required: `overrun_err` pulses once; no `fifo_wr_en`. Deassert `full` and send 0x42: `data_out`=0x42 is written.
- **Start glitch (N=8).**
  - Stimulus: a 1-cycle low pulse on `rxd` in IDLE.
  - Required: `busy` rises, returns to 0 after H=3 further cycles, and no output is produced. A following valid 0x5A is received correctly.
- **Reset mid-frame.**
  - Stimulus: assert `rst` for 1 cycle during data bit 4 of a frame.
  - Required: all outputs read 0 on the next cycle and no write occurs for the aborted frame. With `UART_RX_SYNC_EN`, rerun the first scenario and confirm the strobe arrives 12 cycles after the start edge.
